// File: rtl/shadow_stack_pkg.sv
// Shared types for the return-address shadow stack controller:
// controller states, violation kinds and the accepted-event record.
package shadow_stack_pkg;

  localparam int SS_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    VK_NONE      = 2'd0,
    VK_MISMATCH  = 2'd1,
    VK_UNDERFLOW = 2'd2,
    VK_OVERFLOW  = 2'd3
  } viol_kind_e;

  typedef struct packed {
    logic                 valid;
    logic                 isRet;
    logic [SS_DATA_W-1:0] addr;
  } ss_event_t;

endpackage

// File: rtl/shadow_stack_ctrl_if.sv
// Call/return handshake bundle between the commit stage (master)
// and the shadow stack controller (slave).
interface shadow_stack_ctrl_if #(
  parameter int DATA_W = shadow_stack_pkg::SS_DATA_W
);

  logic              i_call_valid;
  logic [DATA_W-1:0] i_call_addr;
  logic              o_call_ready;
  logic              i_ret_valid;
  logic [DATA_W-1:0] i_ret_target;
  logic              o_ret_ready;

  modport master (
    output i_call_valid, i_call_addr, i_ret_valid, i_ret_target,
    input  o_call_ready, o_ret_ready
  );

  modport slave (
    input  i_call_valid, i_call_addr, i_ret_valid, i_ret_target,
    output o_call_ready, o_ret_ready
  );

endinterface

// File: rtl/ras_shadow_stack.sv
// Register-based LIFO holding return addresses. Push on a full stack and
// pop on an empty stack are ignored. o_sp is the current occupancy.
module ras_shadow_stack #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 8,
  parameter int SP_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [DATA_W-1:0]   i_data,
  output logic [DATA_W-1:0]   o_top,
  output logic                o_valid,
  output logic                o_full,
  output logic                o_empty,
  output logic [SP_WIDTH-1:0] o_sp
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [SP_WIDTH-1:0] r_sp;
  logic [IDX_W-1:0]    w_wrIdx;
  logic [IDX_W-1:0]    w_topIdx;
  logic                w_doPush;
  logic                w_doPop;

  assign w_wrIdx  = r_sp[IDX_W-1:0];
  assign w_topIdx = w_wrIdx - IDX_W'(1);
  assign o_empty  = (r_sp == '0);
  assign o_full   = (r_sp == SP_WIDTH'(DEPTH));
  assign o_valid  = ~o_empty;
  assign o_top    = r_mem[w_topIdx];
  assign o_sp     = r_sp;
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;

  // Entry storage; contents need no reset because the pointer defines validity.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[w_wrIdx] <= i_data;
    end
  end

  // Stack pointer tracks occupancy; cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (w_doPush) begin
      r_sp <= r_sp + SP_WIDTH'(1);
    end else if (w_doPop) begin
      r_sp <= r_sp - SP_WIDTH'(1);
    end
  end

endmodule

// File: rtl/shadow_stack_ctrl.sv
// Shadow stack sequencing controller: registers one committed call/return
// per cycle, pushes/pops/compares from that register in the following cycle,
// latches sticky violations (HALT until i_clear) and drains the stack on flush.
// Optional feature macro: SHADOW_STACK_OVERFLOW_TOLERANT_EN (calls on a full
// stack are counted as lost instead of raising an overflow violation).
module shadow_stack_ctrl
  import shadow_stack_pkg::*;
#(
  parameter int DATA_W   = SS_DATA_W,
  parameter int DEPTH    = 8,
  parameter int SP_WIDTH = 32,
  parameter int LOST_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  shadow_stack_ctrl_if.slave   bus,
  input  logic                 i_flush,
  input  logic                 i_clear,
  output logic                 o_flush_done,
  output logic                 o_violation,
  output logic [1:0]           o_viol_kind,
  output logic [DATA_W-1:0]    o_viol_addr,
  output logic [DATA_W-1:0]    o_viol_expected,
  output logic [SP_WIDTH-1:0]  o_depth
);

  state_e              r_state;
  state_e              w_nextState;
  ss_event_t           r_evt;
  logic                r_violation;
  viol_kind_e          r_violKind;
  logic [DATA_W-1:0]   r_violAddr;
  logic [DATA_W-1:0]   r_violExpected;
  logic                r_flushDone;

  logic                w_push;
  logic                w_pop;
  logic [DATA_W-1:0]   w_top;
  logic                w_full;
  logic                w_empty;
  logic                w_unusedValid;
  logic [SP_WIDTH-1:0] w_sp;

  logic [LOST_W-1:0]   w_lost;
  logic                w_lostInc;
  logic                w_lostDec;
  logic                w_lostClr;

  logic                w_hazard;
  logic                w_retReady;
  logic                w_callReady;
  logic                w_violSet;
  logic                w_violClr;
  viol_kind_e          w_violKindNext;
  logic [DATA_W-1:0]   w_violAddrNext;
  logic [DATA_W-1:0]   w_violExpNext;
  logic                w_flushDoneNext;

  ras_shadow_stack #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .SP_WIDTH (SP_WIDTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (~rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_evt.addr),
    .o_top   (w_top),
    .o_valid (w_unusedValid),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_sp    (w_sp)
  );

  assign w_hazard = r_evt.valid & r_evt.isRet &
                    (w_empty ? (w_lost == '0) : (w_top != r_evt.addr));

  assign w_retReady  = ~rst & (r_state == ST_RUN) & ~i_flush & ~w_hazard;
  assign w_callReady = w_retReady & ~bus.i_ret_valid;

  assign bus.o_ret_ready  = w_retReady;
  assign bus.o_call_ready = w_callReady;

  assign o_flush_done    = r_flushDone;
  assign o_violation     = r_violation;
  assign o_viol_kind     = r_violKind;
  assign o_viol_addr     = r_violAddr;
  assign o_viol_expected = r_violExpected;
  assign o_depth         = w_sp;

`ifdef SHADOW_STACK_OVERFLOW_TOLERANT_EN
  logic [LOST_W-1:0] r_lost;

  // Lost-entry counter: counts dropped calls, consumed by returns on an empty stack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lost <= '0;
    end else if (w_lostClr) begin
      r_lost <= '0;
    end else if (w_lostInc) begin
      r_lost <= r_lost + LOST_W'(1);
    end else if (w_lostDec) begin
      r_lost <= r_lost - LOST_W'(1);
    end
  end

  assign w_lost = r_lost;
`else
  logic w_unusedLost;

  assign w_lost       = '0;
  assign w_unusedLost = w_lostInc | w_lostDec | w_lostClr;
`endif

  // Event register: captures the accepted event, return winning over call.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt <= '0;
    end else if (bus.i_ret_valid & w_retReady) begin
      r_evt <= '{valid: 1'b1, isRet: 1'b1, addr: bus.i_ret_target};
    end else if (bus.i_call_valid & w_callReady) begin
      r_evt <= '{valid: 1'b1, isRet: 1'b0, addr: bus.i_call_addr};
    end else begin
      r_evt <= '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus stack/counter/violation controls for the current cycle.
  always_comb begin
    w_nextState     = r_state;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_lostInc       = 1'b0;
    w_lostDec       = 1'b0;
    w_lostClr       = 1'b0;
    w_violSet       = 1'b0;
    w_violClr       = 1'b0;
    w_violKindNext  = VK_NONE;
    w_violAddrNext  = '0;
    w_violExpNext   = '0;
    w_flushDoneNext = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (r_evt.valid) begin
          if (r_evt.isRet) begin
            if (!w_empty) begin
              w_pop = 1'b1;
              if (w_top != r_evt.addr) begin
                w_violSet      = 1'b1;
                w_violKindNext = VK_MISMATCH;
                w_violAddrNext = r_evt.addr;
                w_violExpNext  = w_top;
              end
            end else if (w_lost != '0) begin
              w_lostDec = 1'b1;
            end else begin
              w_violSet      = 1'b1;
              w_violKindNext = VK_UNDERFLOW;
              w_violAddrNext = r_evt.addr;
            end
          end else begin
            if (!w_full) begin
              w_push = 1'b1;
            end else begin
`ifdef SHADOW_STACK_OVERFLOW_TOLERANT_EN
              w_lostInc = (w_lost != '1);
`else
              w_violSet      = 1'b1;
              w_violKindNext = VK_OVERFLOW;
`endif
            end
          end
        end
        if (w_violSet) begin
          w_nextState = ST_HALT;
        end else if (i_flush) begin
          w_nextState = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!w_empty) begin
          w_pop = 1'b1;
        end else begin
          w_lostClr       = 1'b1;
          w_flushDoneNext = 1'b1;
          w_nextState     = ST_RUN;
        end
      end
      ST_HALT: begin
        if (i_clear) begin
          w_violClr   = 1'b1;
          w_nextState = ST_FLUSH;
        end
      end
      default: begin
        w_nextState = ST_RUN;
      end
    endcase
  end

  // Sticky violation record: loaded on a violation, wiped by i_clear in HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_violation    <= 1'b0;
      r_violKind     <= VK_NONE;
      r_violAddr     <= '0;
      r_violExpected <= '0;
    end else if (w_violSet) begin
      r_violation    <= 1'b1;
      r_violKind     <= w_violKindNext;
      r_violAddr     <= w_violAddrNext;
      r_violExpected <= w_violExpNext;
    end else if (w_violClr) begin
      r_violation    <= 1'b0;
      r_violKind     <= VK_NONE;
      r_violAddr     <= '0;
      r_violExpected <= '0;
    end
  end

  // One-cycle flush completion pulse, coincident with the return to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flushDone <= 1'b0;
    end else begin
      r_flushDone <= w_flushDoneNext;
    end
  end

endmodule
